// File: rtl/tdm_demux4_4bit_pkg.sv
// dsd_pkg: shared types and constants for the TDM nibble demultiplexer
package dsd_pkg;
  typedef enum logic {IDLE, COLLECT} tdm_state_t;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
endpackage

// File: rtl/tdm_demux4_4bit_if.sv
// tdm_demux4_4bit_if: serial beat input plus committed frame outputs of the demux
//   master: drives in_valid/in_sync/in_data, observes the frame outputs
//   slave : consumes beats, drives out0..out3, frame_valid, frame_err, slot_exp, err_count
interface tdm_demux4_4bit_if #(parameter int DW = 4, parameter int ERRW = 8);
  import dsd_pkg::*;
  logic in_valid;
  logic in_sync;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out0, out1, out2, out3;
  logic frame_valid;
  logic frame_err;
  logic [SLOT_W-1:0] slot_exp;
  logic [ERRW-1:0] err_count;
  modport master (
    output in_valid, in_sync, in_data,
    input out0, out1, out2, out3, frame_valid, frame_err, slot_exp, err_count
  );
  modport slave (
    input in_valid, in_sync, in_data,
    output out0, out1, out2, out3, frame_valid, frame_err, slot_exp, err_count
  );
endinterface

// File: rtl/tdm_demux4_4bit_slot_reg.sv
// demux_slot_reg: DW-bit register with load enable and async active-low reset
//   clk, rst_n : clock, async reset
//   en, d      : load enable and data
//   q          : registered value
module demux_slot_reg #(parameter int DW = 4) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/tdm_demux4_4bit.sv
// tdm_demux4_4bit: rebuilds four DW-bit slots from a TDM beat stream into a committed frame
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of tdm_demux4_4bit_if (beats in, frame/status out)
module tdm_demux4_4bit
  import dsd_pkg::*;
#(
  parameter int DW = 4,
  parameter int TIMEOUT = 16,
  parameter int ERRW = 8
) (
  input logic clk,
  input logic rst_n,
  tdm_demux4_4bit_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  tdm_state_t state, state_d;
  logic [SLOT_W-1:0] slot_exp, slot_d, slot_sel;
  logic [CW-1:0] cnt, cnt_d;
  logic frame_valid, frame_err, fe_d;
  logic [ERRW-1:0] err_count;
  logic sync_beat, data_beat, expire, commit;
  logic [NUM_SLOTS-1:0] stage_en;
  logic [DW-1:0] stage_q [NUM_SLOTS];
  logic [DW-1:0] out_q [NUM_SLOTS];
  always_comb begin
    sync_beat = bus.in_valid && bus.in_sync;
    data_beat = bus.in_valid && !bus.in_sync && state == COLLECT;
    expire = state == COLLECT && !bus.in_valid && cnt == CNT_LAST;
    commit = data_beat && slot_exp == SLOT_W'(NUM_SLOTS - 1);
    fe_d = (state == COLLECT && sync_beat) || expire;
    state_d = sync_beat ? COLLECT : (commit || expire) ? IDLE : state;
    slot_d = sync_beat ? SLOT_W'(1) : (commit || expire) ? '0 : data_beat ? slot_exp + SLOT_W'(1) : slot_exp;
    cnt_d = (state == COLLECT && !bus.in_valid && !expire) ? cnt + CW'(1) : '0;
    slot_sel = sync_beat ? '0 : slot_exp;
    stage_en = (sync_beat || data_beat) ? NUM_SLOTS'(1) << slot_sel : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      slot_exp <= '0;
      cnt <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_d;
      slot_exp <= slot_d;
      cnt <= cnt_d;
      frame_valid <= commit;
      frame_err <= fe_d;
      err_count <= err_count + ERRW'(fe_d && err_count != '1);
    end
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    demux_slot_reg #(.DW(DW)) u_stage (
      .clk(clk), .rst_n(rst_n), .en(stage_en[i]), .d(bus.in_data), .q(stage_q[i])
    );
    // the last slot commits straight from the bus so the frame lands one edge after its final beat
    demux_slot_reg #(.DW(DW)) u_out (
      .clk(clk), .rst_n(rst_n), .en(commit),
      .d(i == NUM_SLOTS - 1 ? bus.in_data : stage_q[i]), .q(out_q[i])
    );
  end
  assign bus.out0 = out_q[0];
  assign bus.out1 = out_q[1];
  assign bus.out2 = out_q[2];
  assign bus.out3 = out_q[3];
  assign bus.frame_valid = frame_valid;
  assign bus.frame_err = frame_err;
  assign bus.slot_exp = slot_exp;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_tdm_demux4_4bit.sv
// tb_tdm_demux4_4bit: directed self-checking bench for tdm_demux4_4bit
module tb_tdm_demux4_4bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  tdm_demux4_4bit_if #(.DW(4), .ERRW(8)) bus ();
  tdm_demux4_4bit #(.DW(4), .TIMEOUT(16), .ERRW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    bus.in_valid = v;
    bus.in_sync = s;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [15:0] exp);
    chk(tag, {bus.out0, bus.out1, bus.out2, bus.out3}, {16'h0, exp});
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sync = 1'b0;
    bus.in_data = '0;
    #12;
    chk_out("reset_out", 16'h0000);
    chk("reset_fv", bus.frame_valid, 0);
    chk("reset_fe", bus.frame_err, 0);
    chk("reset_err", bus.err_count, 0);
    chk("reset_slot", bus.slot_exp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, 4'h3);
    chk("f1_slot", bus.slot_exp, 1);
    step(1, 0, 4'h5);
    step(1, 0, 4'hA);
    chk_out("f1_hold", 16'h0000);
    step(1, 0, 4'hF);
    chk("f1_fv", bus.frame_valid, 1);
    chk_out("f1_out", 16'h35AF);
    chk("f1_slot0", bus.slot_exp, 0);
    step(0, 0, 4'h0);
    chk("f1_fv_pulse", bus.frame_valid, 0);
    chk("f1_err", bus.err_count, 0);
    step(1, 1, 4'h1);
    step(1, 0, 4'h2);
    step(1, 0, 4'h3);
    step(1, 1, 4'h7);
    chk("early_fe", bus.frame_err, 1);
    chk("early_fv", bus.frame_valid, 0);
    chk_out("early_hold", 16'h35AF);
    chk("early_err", bus.err_count, 1);
    step(1, 0, 4'h8);
    chk("early_fe_pulse", bus.frame_err, 0);
    step(1, 0, 4'h9);
    step(1, 0, 4'hC);
    chk("early_fv", bus.frame_valid, 1);
    chk_out("early_out", 16'h789C);
    chk("early_err2", bus.err_count, 1);
    step(1, 1, 4'h4);
    step(1, 0, 4'h6);
    for (int i = 0; i < 15; i++) step(0, 0, 4'h0);
    chk("to_early_fe", bus.frame_err, 0);
    chk("to_slot_pre", bus.slot_exp, 2);
    step(0, 0, 4'h0);
    chk("to_fe", bus.frame_err, 1);
    chk("to_slot", bus.slot_exp, 0);
    chk_out("to_hold", 16'h789C);
    chk("to_err", bus.err_count, 2);
    step(1, 0, 4'h5);
    chk("drop_fe", bus.frame_err, 0);
    chk("drop_slot", bus.slot_exp, 0);
    chk("drop_err", bus.err_count, 2);
    step(0, 0, 4'h0);
    step(1, 1, 4'hE);
    step(1, 0, 4'hD);
    step(1, 0, 4'hC);
    step(1, 0, 4'hB);
    chk("b2b_fv1", bus.frame_valid, 1);
    chk_out("b2b_out1", 16'hEDCB);
    step(1, 1, 4'h1);
    chk("b2b_fv_gap", bus.frame_valid, 0);
    chk("b2b_fe_gap", bus.frame_err, 0);
    step(1, 0, 4'h2);
    step(1, 0, 4'h3);
    step(1, 0, 4'h4);
    chk("b2b_fv2", bus.frame_valid, 1);
    chk_out("b2b_out2", 16'h1234);
    step(1, 1, 4'h5);
    step(1, 0, 4'h6);
    step(1, 0, 4'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_out", 16'h0000);
    chk("rst_slot", bus.slot_exp, 0);
    chk("rst_err", bus.err_count, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_fe", bus.frame_err, 0);
    step(1, 1, 4'h9);
    step(1, 0, 4'h9);
    step(1, 0, 4'h9);
    step(1, 0, 4'h9);
    chk("post_rst_fv", bus.frame_valid, 1);
    chk("post_rst_fe", bus.frame_err, 0);
    chk_out("post_rst_out", 16'h9999);
    step(1, 1, 4'h1);
    for (int i = 0; i < 254; i++) step(1, 1, 4'h1);
    chk("sat_254", bus.err_count, 254);
    for (int i = 0; i < 6; i++) step(1, 1, 4'h1);
    chk("sat_ff", bus.err_count, 8'hFF);
    chk("sat_fe", bus.frame_err, 1);
    chk_out("sat_hold", 16'h9999);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
